mul_unit: RTL
=============

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous, active-high reset.
REQ-002 The block SHALL have port start  input  1, the request strobe, sampled only in IDLE.
REQ-003 The block SHALL have port kill  input  1, a pipeline flush that abandons the operation in flight.
REQ-004 The block SHALL have port mul_op  input  4, taken from the decoder and encoded as MUL_MUL / MUL_MULH / MUL_MULHSU / MUL_MULHU from core.svh; value 4'd0 means no operation.
REQ-005 The block SHALL have port a  input  32, the rs1 operand.
REQ-006 The block SHALL have port b  input  32, the rs2 operand.
REQ-007 The block SHALL have port busy  output  1, high while state is CALC or FIX, for pipeline stall.
REQ-008 The block SHALL have port done  output  1, a one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result  output  32, registered and held until the next done.

Function
REQ-010 The FSM SHALL have states IDLE, CALC, FIX, DONE; all outputs SHALL be registered or decoded from state only.
REQ-011 In IDLE, start=1 with mul_op in {MUL,MULH,MULHSU,MULHU} and kill=0 SHALL latch mul_op, a and b and go to CALC; any other mul_op SHALL be ignored (stay IDLE, no done).
REQ-012 Signedness: a_signed for MULH and MULHSU; b_signed for MULH only; MUL SHALL be computed as unsigned, since the low word is identical.
REQ-013 At latch, operand magnitudes SHALL be computed, absolute value if signed and bit31=1; neg = (a_signed&a[31]) ^ (b_signed&b[31]).
REQ-014 The magnitude 0x80000000 SHALL be treated as unsigned 2^31, with no overflow special case.
REQ-015 CALC SHALL last exactly 32 cycles, using a radix-2 shift-add into a 64-bit accumulator and a 5-bit iteration counter that wraps 31->0 on exit to FIX.
REQ-016 FIX (1 cycle) SHALL two's-complement-negate the 64-bit product if neg, then select: MUL -> [31:0]; MULH/MULHSU/MULHU -> [63:32]; it SHALL load result and go to DONE.
REQ-017 DONE (1 cycle) SHALL assert done=1 and return to IDLE; start SHALL be ignored in DONE.
REQ-018 Latency: with start accepted in cycle 0, CALC SHALL span cycles 1-32, FIX cycle 33, and done cycle 34; the next accept SHALL be possible no earlier than cycle 35.
REQ-019 busy SHALL be 1 in cycles 1-33 and 0 in IDLE and DONE.
REQ-020 kill=1 in CALC or FIX SHALL return to IDLE on the next edge with no done pulse and result unchanged.
REQ-021 kill in DONE SHALL NOT suppress that cycle's done.
REQ-022 When start and kill are both high in IDLE, kill SHALL win and start SHALL NOT be accepted.
REQ-023 Operand inputs SHALL be don't-care after the latch cycle, and changes to them SHALL NOT affect the result.

Reset
REQ-024 reset=1 SHALL force state=IDLE, busy=0, done=0, result=32'h0, counter=0 and accumulator=0 at the next edge, including mid-CALC; no done SHALL follow.
REQ-025 reset SHALL take priority over start and kill.

Verification
REQ-026 MUL a=0x00000007, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly at cycle 34, busy high in cycles 1-33.
REQ-027 MULH a=b=0x80000000 -> 0x40000000; MULH a=b=0xFFFFFFFF -> 0x00000000.
REQ-028 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 kill at cycle 10 of a MUL -> busy=0 at cycle 11, no done, result keeps its prior value; a new start at cycle 11 -> done at cycle 45.
REQ-030 reset at cycle 20 mid-CALC -> all outputs at reset values next cycle, no done; start with mul_op=0 -> stays IDLE, busy=0.
REQ-031 Back-to-back requests, including start held high through DONE: -> second operation accepted only in IDLE, two done pulses exactly 35 cycles apart, randomized operands checked against a 64-bit reference model.

Source files
------------

// File: rtl/mul_unit.sv
// Sequential 32x32 multiplier for the M-extension MUL/MULH/MULHSU/MULHU ops.
// Operands are reduced to magnitudes at accept time. A radix-2 shift-add
// then runs for 32 cycles, and the sign is applied to the 64-bit product at the end.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start with a valid mul_op
//   CALC  | 32 shift-add iterations into the 64-bit accumulator
//   FIX   | apply sign, select low/high word, load result
//   DONE  | one-cycle done pulse, start ignored
module mul_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        kill,
   input  logic [3:0]  mul_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [3:0] MUL_MUL    = 4'd1;
   localparam logic [3:0] MUL_MULH   = 4'd2;
   localparam logic [3:0] MUL_MULHSU = 4'd3;
   localparam logic [3:0] MUL_MULHU  = 4'd4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state;
   logic [3:0]  op_q;
   logic        neg_q;
   logic [4:0]  cnt;
   logic [63:0] acc;
   logic [63:0] mcand;
   logic [31:0] mplier;

   logic        op_valid;
   logic        a_signed;
   logic        b_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [63:0] acc_next;
   logic [63:0] prod_fix;

   // Operand decode for the accept cycle; 0x80000000 negates to itself,
   // which is exactly the unsigned magnitude 2^31.
   always_comb begin
      op_valid = (mul_op == MUL_MUL) || (mul_op == MUL_MULH) ||
                 (mul_op == MUL_MULHSU) || (mul_op == MUL_MULHU);
      a_signed = (mul_op == MUL_MULH) || (mul_op == MUL_MULHSU);
      b_signed = (mul_op == MUL_MULH);
      a_neg    = a_signed & a[31];
      b_neg    = b_signed & b[31];
      a_mag    = a_neg ? (~a + 32'd1) : a;
      b_mag    = b_neg ? (~b + 32'd1) : b;
   end

   // Shift-add step and final sign correction.
   always_comb begin
      acc_next = mplier[0] ? (acc + mcand) : acc;
      prod_fix = neg_q ? (~acc + 64'd1) : acc;
   end

   // Sequencer and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         op_q   <= 4'd0;
         neg_q  <= 1'b0;
         cnt    <= 5'd0;
         acc    <= 64'd0;
         mcand  <= 64'd0;
         mplier <= 32'd0;
         result <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !kill && op_valid) begin
                  op_q   <= mul_op;
                  neg_q  <= a_neg ^ b_neg;
                  mcand  <= {32'd0, a_mag};
                  mplier <= b_mag;
                  acc    <= 64'd0;
                  cnt    <= 5'd0;
                  state  <= S_CALC;
               end
            end
            S_CALC: begin
               if (kill) begin
                  cnt   <= 5'd0;
                  state <= S_IDLE;
               end else begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 5'd1;
                  if (cnt == 5'd31) begin
                     state <= S_FIX;
                  end
               end
            end
            S_FIX: begin
               if (kill) begin
                  state <= S_IDLE;
               end else begin
                  result <= (op_q == MUL_MUL) ? prod_fix[31:0] : prod_fix[63:32];
                  state  <= S_DONE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Status outputs decoded from state only.
   assign busy = (state == S_CALC) || (state == S_FIX);
   assign done = (state == S_DONE);

endmodule
